// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a single-outstanding-request fetcher feeding a
// 2-entry {instruction, pc} buffer, with branch redirect and stale-ack draining.
module instruction_fetch #(
  parameter int instructionWidth = 32,
  parameter int addrWidth        = 16,
  parameter int RESET_PC         = 0,
  parameter int PC_STEP          = 1
) (
  input  logic                        clk,
  input  logic                        clear,
  output logic                        memReq,
  output logic [addrWidth-1:0]        memAddr,
  input  logic                        memAck,
  input  logic [instructionWidth-1:0] memData,
  output logic [instructionWidth-1:0] instrOut,
  output logic [addrWidth-1:0]        instrPc,
  output logic                        instrValid,
  input  logic                        irWrite,
  input  logic                        branchTaken,
  input  logic [addrWidth-1:0]        branchTarget
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_SPACE, DRAIN} state_t;

  typedef struct packed {
    logic [instructionWidth-1:0] instr;
    logic [addrWidth-1:0]        pc;
  } entry_t;

  state_t                 state;
  entry_t [1:0]           fifo;
  logic [1:0]             count;
  logic [addrWidth-1:0]   fetch_pc;
  logic [addrWidth-1:0]   req_addr;
  logic                   mem_req;

  logic                   pop;
  logic                   push;
  logic [1:0]             cnt_pop;
  logic [1:0]             cnt_next;
  logic [addrWidth-1:0]   pc_next;

  // Redirects take priority: a branch cycle neither pops nor pushes.
  assign pop      = irWrite && (count != 2'd0) && !branchTaken;
  assign push     = (state == FETCH) && memAck && !branchTaken;
  assign cnt_pop  = count - {1'b0, pop};
  assign cnt_next = cnt_pop + {1'b0, push};
  assign pc_next  = fetch_pc + addrWidth'(PC_STEP);

  always_ff @(posedge clk) begin
    if (!clear) begin
      state    <= IDLE;
      count    <= 2'd0;
      fifo     <= '0;
      fetch_pc <= addrWidth'(RESET_PC);
      req_addr <= addrWidth'(RESET_PC);
      mem_req  <= 1'b0;
    end else if (branchTaken) begin
      count    <= 2'd0;
      fetch_pc <= branchTarget;
      mem_req  <= 1'b1;
      // An unanswered request must still be retired before redirecting.
      if ((state == FETCH || state == DRAIN) && !memAck) begin
        state <= DRAIN;
      end else begin
        state    <= FETCH;
        req_addr <= branchTarget;
      end
    end else begin
      if (pop) fifo[0] <= fifo[1];
      if (push) begin
        if (cnt_pop == 2'd0) fifo[0] <= entry_t'{instr: memData, pc: fetch_pc};
        else                 fifo[1] <= entry_t'{instr: memData, pc: fetch_pc};
      end
      count <= cnt_next;
      case (state)
        IDLE: begin
          state    <= FETCH;
          mem_req  <= 1'b1;
          req_addr <= fetch_pc;
        end
        FETCH: begin
          if (memAck) begin
            fetch_pc <= pc_next;
            req_addr <= pc_next;
            if (cnt_next == 2'd2) begin
              state   <= WAIT_SPACE;
              mem_req <= 1'b0;
            end
          end
        end
        WAIT_SPACE: begin
          if (pop) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            req_addr <= fetch_pc;
          end
        end
        DRAIN: begin
          if (memAck) begin
            state    <= FETCH;
            req_addr <= fetch_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign memReq     = mem_req;
  assign memAddr    = req_addr;
  assign instrValid = (count != 2'd0);
  assign instrOut   = instrValid ? fifo[0].instr : '0;
  assign instrPc    = instrValid ? fifo[0].pc    : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a queue-based reference model checked
// every cycle, plus literal checkpoints along the directed sequence.
module tb_instruction_fetch;
  localparam int IW = 32;
  localparam int AW = 16;
  localparam int RESET_PC = 0;
  localparam int PC_STEP = 1;

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memAck = 1'b0;
  logic [IW-1:0] memData = '0;
  logic [IW-1:0] instrOut;
  logic [AW-1:0] instrPc;
  logic          instrValid;
  logic          irWrite = 1'b0;
  logic          branchTaken = 1'b0;
  logic [AW-1:0] branchTarget = '0;

  instruction_fetch #(
    .instructionWidth(IW), .addrWidth(AW), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)
  ) dut (
    .clk(clk), .clear(clear), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .instrOut(instrOut), .instrPc(instrPc),
    .instrValid(instrValid), .irWrite(irWrite), .branchTaken(branchTaken),
    .branchTarget(branchTarget)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched words, next fetch address, request
  // address, and whether the outstanding request is dead (to be discarded).
  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc    = '0;
  logic [AW-1:0] m_addr  = '0;
  bit            m_req   = 1'b0;
  bit            m_stale = 1'b0;
  bit            m_start = 1'b1;

  task automatic model_update();
    bit popped;
    if (!clear) begin
      mq.delete();
      m_pc = AW'(RESET_PC); m_addr = AW'(RESET_PC);
      m_req = 1'b0; m_stale = 1'b0; m_start = 1'b1;
    end else if (branchTaken) begin
      mq.delete();
      m_pc = branchTarget; m_start = 1'b0;
      if (m_req && !memAck) m_stale = 1'b1;
      else begin m_req = 1'b1; m_stale = 1'b0; m_addr = branchTarget; end
    end else if (m_stale) begin
      if (memAck) begin m_stale = 1'b0; m_addr = m_pc; end
    end else if (m_start) begin
      m_start = 1'b0; m_req = 1'b1; m_addr = m_pc;
    end else begin
      popped = irWrite && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      if (m_req && memAck) begin
        mq.push_back('{instr: memData, pc: m_pc});
        m_pc = m_pc + AW'(PC_STEP);
        m_addr = m_pc;
        m_req = (mq.size() < 2);
      end else if (!m_req && popped) begin
        m_req = 1'b1; m_addr = m_pc;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("memReq", {63'd0, memReq}, {63'd0, m_req});
      if (m_req) check("memAddr", 64'(memAddr), 64'(m_addr));
      check("instrValid", {63'd0, instrValid}, {63'd0, mq.size() != 0});
      check("instrOut", 64'(instrOut), mq.size() != 0 ? 64'(mq[0].instr) : 64'd0);
      check("instrPc", 64'(instrPc), mq.size() != 0 ? 64'(mq[0].pc) : 64'd0);
    end
  end

  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Apply one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input bit clr, input bit ack, input logic [IW-1:0] data,
                      input bit irw, input bit br, input logic [AW-1:0] tgt);
    clear = clr; memAck = ack; memData = data;
    irWrite = irw; branchTaken = br; branchTarget = tgt;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    // reset
    step(0, 0, '0, 0, 0, '0);
    chk_on = 1'b1;
    step(0, 1, 32'h1111_1111, 0, 0, '0);
    check("rst_memReq", {63'd0, memReq}, 64'd0);
    check("rst_instrValid", {63'd0, instrValid}, 64'd0);
    check("rst_instrOut", 64'(instrOut), 64'd0);

    // release: first request at RESET_PC; ack while idle is ignored
    step(1, 1, 32'h2222_2222, 1, 0, '0);
    check("first_req", {63'd0, memReq}, 64'd1);
    check("first_addr", 64'(memAddr), 64'd0);
    check("idle_ack_ignored", {63'd0, instrValid}, 64'd0);

    // ack one cycle after each request, no consumer
    step(1, 0, '0, 1, 0, '0);
    step(1, 1, word(16'd0), 0, 0, '0);
    check("lat_valid", {63'd0, instrValid}, 64'd1);
    check("lat_data", 64'(instrOut), 64'hC0DE_0000);
    check("lat_addr1", 64'(memAddr), 64'd1);
    step(1, 0, '0, 0, 0, '0);
    step(1, 1, word(16'd1), 0, 0, '0);
    check("full_noreq", {63'd0, memReq}, 64'd0);
    check("full_pc0", 64'(instrPc), 64'd0);
    step(1, 1, 32'h3333_3333, 0, 0, '0);
    step(1, 0, '0, 0, 0, '0);

    // single pop from full
    step(1, 0, '0, 1, 0, '0);
    check("pop_pc1", 64'(instrPc), 64'd1);
    check("refetch_req", {63'd0, memReq}, 64'd1);
    check("refetch_addr", 64'(memAddr), 64'd2);

    // push+pop each cycle: walk the request address up to 5
    step(1, 1, word(16'd2), 1, 0, '0);
    step(1, 1, word(16'd3), 1, 0, '0);
    step(1, 1, word(16'd4), 1, 0, '0);
    check("walk_addr5", 64'(memAddr), 64'd5);
    check("walk_pc4", 64'(instrPc), 64'd4);

    // branch while request to 5 is pending: drain the stale ack
    step(1, 0, '0, 0, 1, 16'h0040);
    check("drain_addr_kept", 64'(memAddr), 64'd5);
    check("drain_flush", {63'd0, instrValid}, 64'd0);
    step(1, 0, '0, 0, 0, '0);
    step(1, 0, '0, 1, 0, '0);
    step(1, 1, 32'hDEAD_BEEF, 0, 0, '0);
    check("stale_dropped", {63'd0, instrValid}, 64'd0);
    check("redirect_addr", 64'(memAddr), 64'h40);
    step(1, 1, word(16'h40), 0, 0, '0);
    check("redirect_pc", 64'(instrPc), 64'h40);
    check("redirect_data", 64'(instrOut), 64'hC0DE_0040);

    // branch + ack + irWrite with one entry
    step(1, 1, word(16'h41), 1, 1, 16'h0100);
    check("br_ack_empty", {63'd0, instrValid}, 64'd0);
    check("br_ack_addr", 64'(memAddr), 64'h100);

    // wrap at top of address space
    step(1, 1, 32'h5555_5555, 0, 1, 16'hFFFF);
    step(1, 1, word(16'hFFFF), 0, 0, '0);
    check("wrap_addr", 64'(memAddr), 64'd0);
    check("wrap_pc", 64'(instrPc), 64'hFFFF);

    // branch in DRAIN: newest target wins
    step(1, 0, '0, 0, 1, 16'h0200);
    step(1, 0, '0, 0, 1, 16'h0300);
    check("drain2_addr", 64'(memAddr), 64'd0);
    step(1, 1, 32'h6666_6666, 0, 0, '0);
    check("drain2_target", 64'(memAddr), 64'h300);

    // fill, then branch while waiting for space
    step(1, 1, word(16'h300), 0, 0, '0);
    step(1, 1, word(16'h301), 0, 0, '0);
    check("ws_noreq", {63'd0, memReq}, 64'd0);
    step(1, 0, '0, 0, 1, 16'h0500);
    check("ws_br_addr", 64'(memAddr), 64'h500);
    check("ws_br_flush", {63'd0, instrValid}, 64'd0);

    // reset with a request pending and an entry held
    step(1, 1, word(16'h500), 0, 0, '0);
    step(1, 0, '0, 0, 0, '0);
    step(0, 1, 32'h7777_7777, 1, 0, '0);
    check("midrst_req", {63'd0, memReq}, 64'd0);
    check("midrst_valid", {63'd0, instrValid}, 64'd0);
    check("midrst_pc", 64'(instrPc), 64'd0);
    step(1, 1, 32'h8888_8888, 0, 0, '0);
    check("postrst_valid", {63'd0, instrValid}, 64'd0);
    check("postrst_addr", 64'(memAddr), 64'(RESET_PC));
    step(1, 1, word(16'd0), 0, 0, '0);
    check("postrst_pc", 64'(instrPc), 64'(RESET_PC));
    step(1, 0, '0, 0, 0, '0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
